tw_gen_modexp: RTL and testbench
================================

// Module: tw_gen_modexp
// PURPOSE
// Parametrised on-the-fly twiddle generator for N-point NTT, N = 2^log_n, log_n <= LOGN_MAX.
// Per request computes tw = root^e mod q, with e = (j << i) mod (N >> i). Twiddle exponent.
// Modulus q and root are run-time inputs latched at start, so one instance serves any supported N/q.
// Sits between the NTT stage controller (request side) and the butterfly twiddle port.
// PARAMETERS
// LOGN_MAX  5   max log2 transform size; j, i, log_n are LOGN_MAX bits wide
// QW        25  width of q, root and tw_out; internal accumulators are QW+1 bits
// PORTS
// clock    in  1         rising-edge clock
// reset_n  in  1         asynchronous active-low reset
// start    in  1         request strobe; accepted only in IDLE
// j        in  LOGN_MAX  butterfly index
// i        in  LOGN_MAX  stage index
// log_n    in  LOGN_MAX  log2 of transform size for this request
// cfg_q    in  QW        modulus; odd and >= 3
// cfg_root in  QW        primitive N-th root of unity mod cfg_q, < cfg_q
// busy     out 1         high from the cycle after acceptance until done
// done     out 1         one-cycle pulse: tw_out/err valid
// err      out 1         set with done if cfg_q < 3 or cfg_q even; cleared on next accept
// tw_out   out QW        twiddle result, held until next done
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low. Reset (any time, incl. mid-operation):
//   state=IDLE, busy=0, done=0, err=0, tw_out=0; in-flight request is discarded.
// - start with busy=1 is ignored (no queueing). start and done never coincide in IDLE entry:
//   start sampled in the done cycle is ignored; first acceptable start is the cycle after done.
// - States: IDLE -> LOAD -> {MUL -> SQR} x LOGN_MAX -> DONE -> IDLE.
//   IDLE: on start latch j,i,log_n,cfg_q,cfg_root; go LOAD.
//   LOAD (1 cycle): w1 = j << i (2*LOGN_MAX bits, no truncation); m = 2^log_n >> i;
//     if i >= log_n or log_n > LOGN_MAX then e = 0, else e = w1 & (m-1);
//     res = 1, base = cfg_root, bit counter k = 0; check q valid.
//   MUL (QW cycles): p = res*base mod q; commit res = p only if e[k]=1.
//   SQR (QW cycles): base = base*base mod q; k++; after k = LOGN_MAX-1 go DONE, else MUL.
//   DONE (1 cycle): tw_out = res, done=1, busy=0; then IDLE.
// - Modular multiply a*b mod q: interleaved MSB-first over QW bits of b, one bit per cycle:
//   acc = 2*acc; if acc >= q acc -= q; if b bit: acc += a; if acc >= q acc -= q.
//   Both conditional subtracts complete in the same cycle. Operands always < q.
// - Latency fixed, data-independent: done pulses exactly 2*LOGN_MAX*QW + 2 cycles after the
//   accepting edge (252 for defaults). MUL always executes; only its commit is conditional.
// - e = 0 gives tw_out = 1 (including i >= log_n). q invalid: run full latency, tw_out=0, err=1.
// - cfg_root >= cfg_q is not checked; result is then unspecified but still < q.
// TESTING
// 1 q=17,root=2,log_n=3,j=3,i=0 -> e=3, tw_out=8, done at exactly 252 cycles, err=0.
// 2 q=17,root=2,log_n=3,j=5,i=1 -> w1=10,m=4,e=2, tw_out=4; j=0,i=0 -> tw_out=1.
// 3 q=97,root=33,log_n=3,j=3,i=0 -> tw_out=47; j=4,i=0 -> tw_out=96; i=3 -> tw_out=1.
// 4 start re-pulsed at cycles 10 and 251 of a busy request -> ignored, one done only, result
//   of first request; start in done cycle ignored; start next cycle accepted.
// 5 reset_n low at cycle 100 of a request -> busy/done/err/tw_out 0 immediately (async);
//   new request after release gives correct result with full latency.
// 6 q=16 -> done after 252 cycles with err=1, tw_out=0; next valid request clears err.
// - Bench also sweeps all j,i for log_n=1..5 with q=7681 against a software model.

Source files
------------

// File: rtl/tw_gen_modexp.sv
// tw_gen_modexp: on-the-fly NTT twiddle generator, tw = root^((j << i) mod (N >> i)) mod q.
// Fixed-latency square-and-multiply over LOGN_MAX exponent bits using a bit-serial modular multiplier.
module tw_gen_modexp #(
    parameter int LOGN_MAX = 5,
    parameter int QW       = 25
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [LOGN_MAX-1:0] i_j,
    input  logic [LOGN_MAX-1:0] i_i,
    input  logic [LOGN_MAX-1:0] i_log_n,
    input  logic [QW-1:0]       i_cfg_q,
    input  logic [QW-1:0]       i_cfg_root,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [QW-1:0]       o_tw_out
);
    localparam int BW = $clog2(QW);
    localparam int KW = $clog2(LOGN_MAX + 1);
    localparam int EW = 2 * LOGN_MAX;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_SQR, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [LOGN_MAX-1:0] r_j, r_i, r_log_n, r_e, w_e;
    logic [QW-1:0]       r_q, r_root, r_res, r_base, r_acc, r_tw;
    logic [BW-1:0]       r_bit;
    logic [KW-1:0]       r_k;
    logic                r_qbad, r_err;
    logic [EW-1:0]       w_w1, w_mask;
    logic [QW:0]         w_q1, w_dbl, w_sum;
    logic [QW-1:0]       w_d1, w_s1, w_a;
    logic                w_last;

    assign w_last = r_bit == '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_MUL;
            S_MUL:   w_next = w_last ? S_SQR : S_MUL;
            S_SQR:   w_next = !w_last ? S_SQR : (r_k == KW'(LOGN_MAX - 1)) ? S_DONE : S_MUL;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = r_state inside {S_LOAD, S_MUL, S_SQR};
        o_done = r_state == S_DONE;
    end

    // Modulo a power of two is a mask; out-of-range stages collapse to e = 0.
    always_comb begin
        w_w1   = EW'(r_j) << r_i;
        w_mask = (EW'(1) << (r_log_n - r_i)) - EW'(1);
        w_e    = (r_i >= r_log_n || r_log_n > LOGN_MAX'(LOGN_MAX)) ? '0 : LOGN_MAX'(w_w1 & w_mask);
    end

    // One MSB-first step of acc*2 + b_bit*a, reduced twice so acc stays below q.
    always_comb begin
        w_q1  = {1'b0, r_q};
        w_a   = (r_state == S_MUL) ? r_res : r_base;
        w_dbl = {r_acc, 1'b0};
        w_d1  = QW'((w_dbl >= w_q1) ? w_dbl - w_q1 : w_dbl);
        w_sum = {1'b0, w_d1} + (r_base[r_bit] ? {1'b0, w_a} : '0);
        w_s1  = QW'((w_sum >= w_q1) ? w_sum - w_q1 : w_sum);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_j     <= '0;
            r_i     <= '0;
            r_log_n <= '0;
            r_q     <= '0;
            r_root  <= '0;
            r_e     <= '0;
            r_res   <= '0;
            r_base  <= '0;
            r_acc   <= '0;
            r_bit   <= '0;
            r_k     <= '0;
            r_qbad  <= 1'b0;
            r_err   <= 1'b0;
            r_tw    <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_j     <= i_j;
                r_i     <= i_i;
                r_log_n <= i_log_n;
                r_q     <= i_cfg_q;
                r_root  <= i_cfg_root;
                r_err   <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_e    <= w_e;
                r_res  <= QW'(1);
                r_base <= r_root;
                r_acc  <= '0;
                r_bit  <= BW'(QW - 1);
                r_k    <= '0;
                r_qbad <= (r_q < QW'(3)) || !r_q[0];
            end
            if (r_state == S_MUL || r_state == S_SQR) begin
                r_acc <= w_last ? '0 : w_s1;
                r_bit <= w_last ? BW'(QW - 1) : r_bit - 1'b1;
                if (w_last && r_state == S_MUL && r_e[r_k])
                    r_res <= w_s1;
                if (w_last && r_state == S_SQR) begin
                    r_base <= w_s1;
                    r_k    <= r_k + 1'b1;
                end
            end
            if (r_state == S_SQR && w_next == S_DONE) begin
                r_tw  <= r_qbad ? '0 : r_res;
                r_err <= r_qbad;
            end
        end
    end

    assign o_err    = r_err;
    assign o_tw_out = r_tw;
endmodule

// File: tb/tb_tw_gen_modexp.sv
// tb_tw_gen_modexp: scoreboard bench for the twiddle generator.
// Stimulus pushes expected results; a negedge monitor pops and checks on every done pulse.
module tb_tw_gen_modexp;
    localparam int LN  = 5;
    localparam int QW  = 25;
    localparam int LAT = 2 * LN * QW + 2;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [LN-1:0] j = '0, i = '0, log_n = '0;
    logic [QW-1:0] q = '0, root = '0;
    logic          busy, done, err;
    logic [QW-1:0] tw;

    int n_tests = 0, n_fail = 0, cyc = 0, n_id = 0;

    typedef struct {
        int            id;
        logic [QW-1:0] tw;
        logic          err;
        int            t0;
    } exp_t;
    exp_t exp_q[$];

    tw_gen_modexp #(.LOGN_MAX(LN), .QW(QW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_j(j), .i_i(i), .i_log_n(log_n), .i_cfg_q(q), .i_cfg_root(root),
        .o_busy(busy), .o_done(done), .o_err(err), .o_tw_out(tw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [QW-1:0] model(input longint qq, input longint rr, input int ll, input int jj, input int ii);
        longint e, r;
        e = (ii >= ll || ll > LN) ? 0 : ((longint'(jj) << ii) % ((longint'(1) << ll) >> ii));
        r = 1;
        for (longint k = 0; k < e; k++) r = (r * rr) % qq;
        return QW'(r);
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got tw=%0d expected no done", tw);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("req%0d tw", e.id), tw, e.tw);
                check($sformatf("req%0d err", e.id), err, e.err);
                check($sformatf("req%0d latency", e.id), cyc - e.t0 + 1, LAT);
                check($sformatf("req%0d busy_at_done", e.id), busy, 0);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the first busy cycle.
    task automatic issue(input int jj, input int ii, input int ll, input int qq, input int rr,
                         input logic [QW-1:0] etw, input logic eerr);
        j = LN'(jj);
        i = LN'(ii);
        log_n = LN'(ll);
        q = QW'(qq);
        root = QW'(rr);
        start = 1'b1;
        n_id++;
        exp_q.push_back('{n_id, etw, eerr, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        check($sformatf("req%0d busy_after_accept", n_id), busy, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 2 * LAT) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got no done within %0d cycles expected done", 2 * LAT);
        end
        @(negedge clk);
    endtask

    task automatic run(input int jj, input int ii, input int ll, input int qq, input int rr,
                       input logic [QW-1:0] etw, input logic eerr);
        issue(jj, ii, ll, qq, rr, etw, eerr);
        wait_done();
    endtask

    initial begin
        exp_t dropped;
        int   js[6];
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset tw", tw, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(3, 0, 3, 17, 2, 8, 0);
        run(5, 1, 3, 17, 2, 4, 0);
        run(0, 0, 3, 17, 2, 1, 0);
        run(3, 0, 3, 97, 33, 47, 0);
        run(4, 0, 3, 97, 33, 96, 0);
        run(3, 3, 3, 97, 33, 1, 0);
        run(3, 0, 6, 17, 2, 1, 0);
        run(1, 0, 5, 33554431, 33554430, 33554430, 0);
        run(2, 0, 5, 33554431, 33554430, 1, 0);
        run(3, 0, 5, 33554431, 33554430, 33554430, 0);

        // Re-pulsed start while busy and in the done cycle must be ignored.
        issue(4, 0, 3, 97, 33, 96, 0);
        repeat (9) @(negedge clk);
        check("t4 busy_c10", busy, 1);
        j = 3; i = 0; log_n = 3; q = 17; root = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (240) @(negedge clk);
        check("t4 busy_c251", busy, 1);
        j = 3; i = 0; log_n = 3; q = 97; root = 33;
        start = 1'b1;
        @(negedge clk);
        check("t4 done_c252", done, 1);
        @(negedge clk);
        n_id++;
        exp_q.push_back('{n_id, 47, 1'b0, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        wait_done();

        run(2, 0, 3, 16, 3, 0, 1);
        run(1, 0, 3, 1, 0, 0, 1);
        run(1, 0, 3, 17, 2, 2, 0);

        // Asynchronous reset in the middle of a request.
        issue(4, 0, 3, 97, 33, 96, 0);
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5 busy", busy, 0);
        check("t5 done", done, 0);
        check("t5 err", err, 0);
        check("t5 tw", tw, 0);
        dropped = exp_q.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(3, 0, 3, 97, 33, 47, 0);

        for (int ll = 1; ll <= LN; ll++) begin
            js = '{0, 1, 2, (1 << ll) - 1, 1 << (ll - 1), 31};
            for (int ii = 0; ii <= ll; ii++)
                foreach (js[x])
                    run(js[x], ii, ll, 7681, 17, model(7681, 17, ll, js[x], ii), 0);
        end

        check("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
